// File: rtl/irq_pkg.sv
// Shared types and sizes for the interrupt pending/dispatch stage.
package irq_pkg;

   localparam int unsigned N_REQ = 16;
   localparam int unsigned IDX_W = $clog2(N_REQ);

   typedef logic [N_REQ-1:0] req_vec_t;
   typedef logic [IDX_W-1:0] irq_idx_t;

endpackage

// File: rtl/irq_pend_encoder_if.sv
// Valid/ready dispatch channel carrying the selected request index.
interface irq_pend_encoder_if;
   import irq_pkg::*;

   logic     out_valid_o;
   irq_idx_t out_idx_o;
   logic     out_ready_i;

   modport master (
      output out_valid_o,
      output out_idx_o,
      input  out_ready_i
   );

   modport slave (
      input  out_valid_o,
      input  out_idx_o,
      output out_ready_i
   );

endinterface

// File: rtl/prio_sel16.sv
// Combinational 16-way priority select; the highest set index wins.
module prio_sel16
   import irq_pkg::*;
(
   input  req_vec_t cand,
   output irq_idx_t sel,
   output logic     any
);

   always_comb begin
      sel = '0;
      any = |cand;
      // Ascending scan so the highest set bit is the last one written.
      for (int i = 0; i < N_REQ; i++) begin
         if (cand[i]) begin
            sel = irq_idx_t'(i);
         end
      end
   end

endmodule

// File: rtl/irq_pend_encoder.sv
// Pending-request capture with mask and highest-index-first dispatch.
// Optional edge-triggered capture is enabled by defining IRQ_EDGE_DETECT_EN.
module irq_pend_encoder
   import irq_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  req_vec_t                  req_i,
   input  logic                      mask_wr_i,
   input  req_vec_t                  mask_i,
   irq_pend_encoder_if.master        dispatch,
   output req_vec_t                  pend_o,
   output logic                      overflow_o
);

   req_vec_t pend_q, pend_d;
   req_vec_t mask_q;
   logic     valid_q;
   irq_idx_t idx_q;
   logic     ovf_q, ovf_d;

   req_vec_t new_req;
   req_vec_t cand;
   req_vec_t clear;
   irq_idx_t sel;
   logic     any;
   logic     load;
   logic     take;

`ifdef IRQ_EDGE_DETECT_EN
   req_vec_t req_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= '0;
      end else begin
         req_q <= req_i;
      end
   end

   assign new_req = req_i & ~req_q;
`else
   assign new_req = req_i;
`endif

   assign load = !valid_q || dispatch.out_ready_i;
   assign cand = pend_q & ~mask_q;

   prio_sel16 u_prio_sel16 (
      .cand (cand),
      .sel  (sel),
      .any  (any)
   );

   assign take = load && any;

   always_comb begin
      clear = '0;
      if (take) begin
         clear = req_vec_t'(1) << sel;
      end
      // A fresh request on the bit being taken re-pends it.
      pend_d = (pend_q & ~clear) | new_req;
      ovf_d  = |(new_req & pend_q & ~clear);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= '0;
         mask_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         if (mask_wr_i) begin
            mask_q <= mask_i;
         end
         if (load) begin
            valid_q <= any;
            if (any) begin
               idx_q <= sel;
            end
         end
      end
   end

   assign dispatch.out_valid_o = valid_q;
   assign dispatch.out_idx_o   = idx_q;
   assign pend_o               = pend_q;
   assign overflow_o           = ovf_q;

endmodule

// File: tb/tb_irq_pend_encoder.sv
// Self-checking bench for irq_pend_encoder: directed scenarios plus a random run
// checked every cycle against a behavioural model.
module tb_irq_pend_encoder;
   import irq_pkg::*;

   logic     clk;
   logic     rst;
   req_vec_t req;
   logic     mask_wr;
   req_vec_t mask;
   req_vec_t pend;
   logic     ovf;

   irq_pend_encoder_if bus ();

   irq_pend_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req),
      .mask_wr_i  (mask_wr),
      .mask_i     (mask),
      .dispatch   (bus),
      .pend_o     (pend),
      .overflow_o (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   logic [15:0] m_pend  = '0;
   logic [15:0] m_mask  = '0;
   logic        m_valid = 1'b0;
   logic [3:0]  m_idx   = '0;
   logic        m_ovf   = 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
   logic [15:0] m_reqq  = '0;
`endif

   // Advance one clock; the model consumes the inputs present at the edge.
   task automatic tick();
      logic [15:0] nr, clr, n_pend, n_mask;
      logic        n_valid, n_ovf;
      logic [3:0]  n_idx;
      int          top;
      if (rst) begin
         n_pend = '0; n_mask = '0; n_valid = 1'b0; n_idx = '0; n_ovf = 1'b0;
         nr = '0;
      end else begin
`ifdef IRQ_EDGE_DETECT_EN
         nr = req & ~m_reqq;
`else
         nr = req;
`endif
         top = -1;
         for (int i = 15; i >= 0; i--) begin
            if (top < 0 && m_pend[i] && !m_mask[i]) top = i;
         end
         clr     = '0;
         n_valid = m_valid;
         n_idx   = m_idx;
         if (!m_valid || bus.out_ready_i) begin
            if (top >= 0) begin
               clr[top] = 1'b1;
               n_valid  = 1'b1;
               n_idx    = top[3:0];
            end else begin
               n_valid = 1'b0;
            end
         end
         n_ovf  = |(nr & m_pend & ~clr);
         n_pend = (m_pend & ~clr) | nr;
         n_mask = mask_wr ? mask : m_mask;
      end
`ifdef IRQ_EDGE_DETECT_EN
      m_reqq = rst ? 16'h0 : req;
`endif
      @(posedge clk);
      #1;
      m_pend = n_pend; m_mask = n_mask; m_valid = n_valid; m_idx = n_idx; m_ovf = n_ovf;
   endtask

   task automatic idle(input int n);
      req = '0; mask_wr = 1'b0; bus.out_ready_i = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 16'hFFFF; mask_wr = 1'b0; mask = '0; bus.out_ready_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_checks++;
         if ({bus.out_valid_o, bus.out_idx_o, pend, ovf} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got v=%b idx=%0d pend=%h ovf=%b want all 0",
                     c, bus.out_valid_o, bus.out_idx_o, pend, ovf);
         end
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (pend !== 16'hFFFF || bus.out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release1 got pend=%h v=%b want pend=ffff v=0", pend, bus.out_valid_o);
      end
      req = '0;
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== 4'd15 || pend !== 16'h7FFF) begin
         n_fail++;
         $display("FAIL reset_release2 got v=%b idx=%0d pend=%h want v=1 idx=15 pend=7fff",
                  bus.out_valid_o, bus.out_idx_o, pend);
      end
      idle(18);
   endtask

   task automatic test_priority_drain();
      logic [3:0] exp_idx [8] = '{4'd13, 4'd11, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3};
      bus.out_ready_i = 1'b1;
      req = 16'b0010101011111000;
      tick();
      req = '0;
      n_checks++;
      if (pend !== 16'b0010101011111000 || bus.out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_capture got pend=%h v=%b want pend=2af8 v=0", pend, bus.out_valid_o);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         n_checks++;
         if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== exp_idx[k]) begin
            n_fail++;
            $display("FAIL drain_idx k=%0d got v=%b idx=%0d want v=1 idx=%0d",
                     k, bus.out_valid_o, bus.out_idx_o, exp_idx[k]);
         end
      end
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b0 || pend !== 16'h0) begin
         n_fail++;
         $display("FAIL drain_end got v=%b pend=%h want v=0 pend=0", bus.out_valid_o, pend);
      end
   endtask

   task automatic test_back_pressure();
      bus.out_ready_i = 1'b0;
      req = 16'h0006;
      tick();
      req = '0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== 4'd2 || pend !== 16'h0002) begin
            n_fail++;
            $display("FAIL bp_hold c=%0d got v=%b idx=%0d pend=%h want v=1 idx=2 pend=0002",
                     c, bus.out_valid_o, bus.out_idx_o, pend);
         end
      end
      bus.out_ready_i = 1'b1;
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== 4'd1 || pend !== 16'h0) begin
         n_fail++;
         $display("FAIL bp_release got v=%b idx=%0d pend=%h want v=1 idx=1 pend=0",
                  bus.out_valid_o, bus.out_idx_o, pend);
      end
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_end got v=%b want 0", bus.out_valid_o);
      end
   endtask

   task automatic test_mask();
      bus.out_ready_i = 1'b1;
      mask_wr = 1'b1; mask = 16'hFF00;
      tick();
      mask_wr = 1'b0;
      req = 16'h01FE;
      tick();
      req = '0;
      for (int k = 7; k >= 1; k--) begin
         tick();
         n_checks++;
         if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== 4'(k)) begin
            n_fail++;
            $display("FAIL mask_idx got v=%b idx=%0d want v=1 idx=%0d",
                     bus.out_valid_o, bus.out_idx_o, k);
         end
      end
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b0 || pend !== 16'h0100) begin
         n_fail++;
         $display("FAIL mask_hold got v=%b pend=%h want v=0 pend=0100", bus.out_valid_o, pend);
      end
      mask_wr = 1'b1; mask = '0;
      tick();
      mask_wr = 1'b0;
      n_checks++;
      if (bus.out_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_delay got v=%b want 0", bus.out_valid_o);
      end
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== 4'd8 || pend !== 16'h0) begin
         n_fail++;
         $display("FAIL mask_unmask got v=%b idx=%0d pend=%h want v=1 idx=8 pend=0",
                  bus.out_valid_o, bus.out_idx_o, pend);
      end
      idle(2);
   endtask

   task automatic test_overflow();
      int fours = 0;
      bus.out_ready_i = 1'b0;
      req = 16'h0200; tick();
      req = 16'h0000; tick();
      req = 16'h0010; tick();
      req = 16'h0000; tick();
      n_checks++;
      if (ovf !== 1'b0 || pend !== 16'h0010) begin
         n_fail++;
         $display("FAIL ovf_first got ovf=%b pend=%h want ovf=0 pend=0010", ovf, pend);
      end
      req = 16'h0010; tick();
      req = 16'h0000;
      n_checks++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_pulse got %b want 1", ovf);
      end
      tick();
      n_checks++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear got %b want 0", ovf);
      end
      bus.out_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (bus.out_valid_o && bus.out_idx_o == 4'd4) fours++;
      end
      n_checks++;
      if (fours != 1) begin
         n_fail++;
         $display("FAIL ovf_dispatch_count got %0d want 1", fours);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1000; c++) begin
         rst             = ($urandom_range(0, 199) == 0);
         req             = 16'($urandom & $urandom & $urandom);
         mask_wr         = ($urandom_range(0, 7) == 0);
         mask            = 16'($urandom & $urandom);
         bus.out_ready_i = ($urandom_range(0, 3) != 0);
         tick();
         n_checks++;
         if (bus.out_valid_o !== m_valid || bus.out_idx_o !== m_idx || pend !== m_pend ||
             ovf !== m_ovf) begin
            n_fail++;
            $display("FAIL random c=%0d got v=%b idx=%0d pend=%h ovf=%b want v=%b idx=%0d pend=%h ovf=%b",
                     c, bus.out_valid_o, bus.out_idx_o, pend, ovf, m_valid, m_idx, m_pend, m_ovf);
         end
      end
      rst = 1'b0;
      idle(20);
   endtask

   initial begin
      rst = 1'b1; req = '0; mask_wr = 1'b0; mask = '0; bus.out_ready_i = 1'b0;
      test_reset();
      test_priority_drain();
      test_back_pressure();
      test_mask();
      test_overflow();
      idle(4);
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
